// File: rtl/op_sequencer.sv
// Fetch/dispatch sequencer ahead of the FPU: walks operand memory from address 0
// and issues one operation at a time, forwarding each result with its entry index.
module op_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] address,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [1:0]        iss_op,
    output logic [DATA_W-1:0] iss_a,
    output logic [DATA_W-1:0] iss_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [ADDR_W:0] cnt_l;
    logic [TW-1:0]   wcnt;
    logic            last_entry;
    logic            wait_expired;

    // count is at least 1 whenever WAIT is reachable, so count-1 never underflows here
    assign last_entry   = ({1'b0, address} == (cnt_l - (ADDR_W + 1)'(1)));
    assign wait_expired = (wcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            address   <= '0;
            cnt_l     <= '0;
            wcnt      <= '0;
            iss_valid <= 1'b0;
            iss_op    <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                // DONE re-arms on start exactly like IDLE
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt_l   <= count;
                        address <= '0;
                        timeout <= 1'b0;
                        if (count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_FETCH;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    iss_op    <= op;
                    iss_a     <= opA;
                    iss_b     <= opB;
                    iss_valid <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (iss_ready) begin
                        iss_valid <= 1'b0;
                        wcnt      <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt <= wcnt + TW'(1);
                    if (res_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= res_data;
                        out_index <= address;
                        if (last_entry) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            address <= address + ADDR_W'(1);
                            state   <= S_FETCH;
                        end
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: memory and FPU responder modelled in the bench,
// every output sampled on the falling edge.
`timescale 1ns/1ps
module tb_op_sequencer;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] address;
    logic [1:0]        op;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              iss_valid;
    logic              iss_ready;
    logic [1:0]        iss_op;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;
    logic              timeout;

    logic [1:0]  mem_op  [256];
    logic [15:0] mem_a   [256];
    logic [15:0] mem_b   [256];
    logic [15:0] res_tab [256];

    int errors = 0;
    int checks = 0;
    int n_iss, n_res, n_out, rdy_cnt, lat, ready_delay, res_lat, vld_cycles, cyc;
    bit fpu_en, res_pend, v_q, stray;

    op_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count), .address(address),
        .op(op), .opA(opA), .opB(opB),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_a(iss_a), .iss_b(iss_b),
        .res_valid(res_valid), .res_data(res_data),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign op  = mem_op[address];
    assign opA = mem_a[address];
    assign opB = mem_b[address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at the falling edge, then drive the FPU side for the next rising edge
    task automatic tick();
        @(negedge clk);
        if (out_valid) begin
            chk("out_data", 32'(out_data), 32'(res_tab[n_out[7:0]]));
            chk("out_index", 32'(out_index), 32'(n_out[7:0]));
            n_out++;
        end
        if (v_q && iss_ready) begin
            n_iss++;
            res_pend = fpu_en;
            lat      = res_lat;
        end
        v_q = iss_valid;
        res_valid = 1'b0;
        if (res_pend) begin
            if (lat == 0) begin
                res_valid = 1'b1;
                res_data  = res_tab[n_res[7:0]];
                n_res++;
                res_pend  = 1'b0;
            end else begin
                lat--;
            end
        end
        if (stray) begin
            res_valid = 1'b1;
            res_data  = 16'hDEAD;
        end
        if (iss_valid) begin
            vld_cycles++;
            if (n_iss < 256) begin
                chk("iss_addr", 32'(address), 32'(n_iss[7:0]));
                chk("iss_op", 32'(iss_op), 32'(mem_op[n_iss[7:0]]));
                chk("iss_a", 32'(iss_a), 32'(mem_a[n_iss[7:0]]));
                chk("iss_b", 32'(iss_b), 32'(mem_b[n_iss[7:0]]));
            end
            if (rdy_cnt < ready_delay) begin
                iss_ready = 1'b0;
                rdy_cnt++;
            end else begin
                iss_ready = 1'b1;
            end
        end else begin
            iss_ready = 1'b0;
            rdy_cnt   = 0;
        end
    endtask

    task automatic run(input int cnt, input int lim);
        n_iss = 0; n_res = 0; n_out = 0; vld_cycles = 0;
        count = cnt[ADDR_W:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < lim) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; count = '0;
        iss_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        fpu_en = 1'b1; res_pend = 1'b0; v_q = 1'b0; stray = 1'b0;
        ready_delay = 0; res_lat = 0; rdy_cnt = 0; lat = 0;
        n_iss = 0; n_res = 0; n_out = 0; vld_cycles = 0; cyc = 0;
        for (int i = 0; i < 256; i++) begin
            mem_op[i[7:0]]  = i[1:0];
            mem_a[i[7:0]]   = 16'h1000 + 16'(i);
            mem_b[i[7:0]]   = 16'h8000 - 16'(i);
            res_tab[i[7:0]] = 16'h5000 ^ 16'(i);
        end
        mem_op[0] = 2'b00; mem_a[0] = 16'h3C00; mem_b[0] = 16'h4000; res_tab[0] = 16'h4200;

        // Reset state
        tick(); tick();
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_iss_valid", 32'(iss_valid), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_iss_a", 32'(iss_a), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        reset = 1'b0;
        tick();

        // Stray result in IDLE
        stray = 1'b1; tick(); stray = 1'b0; tick(); tick();
        chk("stray_nout", n_out, 0);
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_done", 32'(done), 32'h0);

        // Reset while entry 1 sits in ISSUE
        n_iss = 0; n_res = 0; n_out = 0;
        count = 9'd3; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20 && n_iss == 0; i++) tick();
        ready_delay = 100;
        for (int i = 0; i < 20 && !(iss_valid && address == 8'd1); i++) tick();
        chk("midrst_pre_valid", 32'(iss_valid), 32'h1);
        chk("midrst_pre_addr", 32'(address), 32'h1);
        reset = 1'b1; tick(); tick();
        chk("midrst_iss_valid", 32'(iss_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_address", 32'(address), 32'h0);
        reset = 1'b0; ready_delay = 0; tick(); tick();
        chk("midrst_nout", n_out, 1);

        // Single op
        run(1, 50);
        chk("single_cyc", cyc, 3);
        chk("single_done", 32'(done), 32'h1);
        chk("single_busy", 32'(busy), 32'h0);
        chk("single_nout", n_out, 1);
        chk("single_niss", n_iss, 1);
        chk("single_out_data", 32'(out_data), 32'h4200);
        chk("single_out_index", 32'(out_index), 32'h0);
        chk("single_iss_a", 32'(iss_a), 32'h3C00);
        chk("single_iss_b", 32'(iss_b), 32'h4000);

        // Backpressure: ready low for 5 ISSUE cycles, accepted on the 6th
        ready_delay = 5;
        run(1, 50);
        chk("bp_valid_cycles", vld_cycles, 6);
        chk("bp_niss", n_iss, 1);
        chk("bp_nout", n_out, 1);
        chk("bp_done", 32'(done), 32'h1);
        ready_delay = 0;

        // Multi-entry at full rate
        run(4, 100);
        chk("multi_cyc", cyc, 12);
        chk("multi_nout", n_out, 4);
        chk("multi_address", 32'(address), 32'h3);
        chk("multi_out_index", 32'(out_index), 32'h3);
        chk("multi_out_data", 32'(out_data), 32'h5003);
        chk("multi_done", 32'(done), 32'h1);

        // Multi-entry with slow ready and slow result
        ready_delay = 1; res_lat = 2;
        run(4, 100);
        chk("slow_nout", n_out, 4);
        chk("slow_niss", n_iss, 4);
        chk("slow_address", 32'(address), 32'h3);
        ready_delay = 0; res_lat = 0;

        // Timeout: no result ever returns
        fpu_en = 1'b0;
        n_iss = 0; n_res = 0; n_out = 0;
        count = 9'd2; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20 && n_iss == 0; i++) tick();
        repeat (7) tick();
        chk("to_done_early", 32'(done), 32'h0);
        chk("to_busy_early", 32'(busy), 32'h1);
        tick();
        chk("to_done", 32'(done), 32'h1);
        chk("to_timeout", 32'(timeout), 32'h1);
        chk("to_nout", n_out, 0);
        chk("to_address", 32'(address), 32'h0);
        fpu_en = 1'b1;
        run(1, 50);
        chk("to_cleared", 32'(timeout), 32'h0);
        chk("to_rerun_nout", n_out, 1);

        // count = 0
        run(0, 10);
        chk("zero_cyc", cyc, 0);
        chk("zero_done", 32'(done), 32'h1);
        tick(); tick();
        chk("zero_niss", n_iss, 0);
        chk("zero_valid_cycles", vld_cycles, 0);
        chk("zero_nout", n_out, 0);

        // count = 256
        run(256, 2000);
        chk("full_cyc", cyc, 768);
        chk("full_nout", n_out, 256);
        chk("full_niss", n_iss, 256);
        chk("full_out_index", 32'(out_index), 32'hFF);
        chk("full_out_data", 32'(out_data), 32'h50FF);
        chk("full_address", 32'(address), 32'hFF);
        chk("full_done", 32'(done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
